// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer family: FSM state encoding and
// the default counter width.
package countdown_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter/timer: host loads N over valid/ready, starts it, and
// gets a one-cycle expired pulse after N enabled clocks (optional auto-reload).
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_expired;
    logic             w_expired_nxt;
    logic             w_load_acc;

    assign load_ready = (r_state != ST_RUN);
    assign busy       = (r_state == ST_RUN);
    assign count_out  = r_count;
    assign expired    = r_expired;
    assign w_load_acc = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= ZERO;
            r_reload  <= ZERO;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    // Priority: abort > load > start > count. Start in IDLE/RUN falls through.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_reload_nxt  = r_reload;
        w_expired_nxt = 1'b0;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = ZERO;
        end else if (w_load_acc) begin
            w_state_nxt  = ST_LOADED;
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
        end else if (start && (r_state == ST_LOADED)) begin
            w_state_nxt = ST_RUN;
        end else if (start && (r_state == ST_DONE)) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = r_reload;
        end else if ((r_state == ST_RUN) && !pause) begin
            if (r_count > ONE) begin
                w_count_nxt = r_count - ONE;
            end else if (r_count == ONE) begin
                w_expired_nxt = 1'b1;
                if (AUTO_RELOAD) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = ZERO;
                    w_state_nxt = ST_DONE;
                end
            end else begin
                // N=0 was loaded: expire once and stop, even with auto-reload
                w_expired_nxt = 1'b1;
                w_state_nxt   = ST_DONE;
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance without and one with
// auto-reload, driven by shared stimulus.
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic         abort;

    logic         load_ready0, busy0, expired0;
    logic [W-1:0] count0;
    logic         load_ready1, busy1, expired1;
    logic [W-1:0] count1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready0), .load_value(load_value),
        .start(start), .pause(pause), .abort(abort),
        .count_out(count0), .busy(busy0), .expired(expired0)
    );

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready1), .load_value(load_value),
        .start(start), .pause(pause), .abort(abort),
        .count_out(count1), .busy(busy1), .expired(expired1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        load_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic load_start(input logic [W-1:0] n);
        load_valid = 1'b1; load_value = n;
        tick();
        load_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int exp_c [8] = '{2, 1, 3, 2, 1, 3, 2, 1};

        rst_n = 1'b0; load_valid = 1'b0; load_value = '0;
        start = 1'b0; pause = 1'b0; abort = 1'b0;
        #3;
        chk("rst_count", count0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ready", load_ready0, 1);
        chk("rst_expired", expired0, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of a run at count 37
        load_start(8'd40);
        tick(); tick(); tick();
        chk("pre_rst_count", count0, 37);
        chk("pre_rst_busy", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_ready", load_ready0, 1);
        chk("mid_rst_expired", expired0, 0);
        chk("mid_rst_count1", count1, 0);
        tick();
        chk("mid_rst_hold_exp", expired0, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_exp", expired0 | expired1, 0);

        // Load 5, start, count to expiry
        clear();
        load_start(8'd5);
        chk("b_count_start", count0, 5);
        chk("b_busy_start", busy0, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("b_count", count0, 5 - i);
            chk("b_expired", expired0, (i == 5) ? 1 : 0);
        end
        chk("b_busy_done", busy0, 0);
        chk("b_ready_done", load_ready0, 1);
        chk("b_reload_count", count1, 5);
        chk("b_reload_exp", expired1, 1);
        chk("b_reload_busy", busy1, 1);
        tick();
        chk("b_exp_single", expired0, 0);
        chk("b_count_hold", count0, 0);

        // Auto-reload with N=3, then abort on a count==1 cycle
        clear();
        load_start(8'd3);
        chk("c_count_start", count1, 3);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("c_count", count1, exp_c[i]);
            chk("c_expired", expired1, (exp_c[i] == 3) ? 1 : 0);
            chk("c_busy", busy1, 1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_abort_count", count1, 0);
        chk("c_abort_exp", expired1, 0);
        chk("c_abort_busy", busy1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_no_pulse", expired1, 0);
        end

        // Pause 4 cycles mid-run; loads during RUN are refused
        clear();
        load_start(8'd10);
        tick(); tick(); tick();
        chk("d_count_prepause", count0, 7);
        chk("d_ready_run", load_ready0, 0);
        pause = 1'b1; load_valid = 1'b1; load_value = 8'd99;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("d_count_paused", count0, 7);
        end
        pause = 1'b0; load_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("d_count", count0, 7 - i);
            chk("d_expired", expired0, (i == 7) ? 1 : 0);
        end

        // N=0: expire one cycle after start, then restart from DONE
        clear();
        load_start(8'd0);
        chk("e_busy_start", busy0, 1);
        tick();
        chk("e_exp0", expired0, 1);
        chk("e_exp1", expired1, 1);
        chk("e_busy1_done", busy1, 0);
        chk("e_count", count0, 0);
        tick();
        chk("e_exp_clear", expired0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e_restart_busy", busy0, 1);
        chk("e_restart_exp", expired0, 0);
        tick();
        chk("e_reexp", expired0, 1);
        chk("e_reexp_busy", busy0, 0);

        // Overwrite in LOADED, abort priority, load beating start
        clear();
        load_valid = 1'b1; load_value = 8'd7;
        tick();
        load_value = 8'd9;
        tick();
        chk("f_overwrite", count0, 9);
        load_value = 8'd11; start = 1'b1; abort = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0; abort = 1'b0;
        chk("f_abort_count", count0, 0);
        chk("f_abort_busy", busy0, 0);
        chk("f_abort_ready", load_ready0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f_idle_start_ign", busy0, 0);
        load_valid = 1'b1; load_value = 8'd12; start = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        chk("f_ld_st_count", count0, 12);
        chk("f_ld_st_busy", busy0, 0);
        tick();
        chk("f_stay_loaded", busy0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f_start_loaded", busy0, 1);
        chk("f_start_count", count0, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
